// File: rtl/trig_gate_gen_if.sv
// trig_gate_gen_if: trigger/config inputs and gate, counter and timestamp outputs of trig_gate_gen
interface trig_gate_gen_if #(
    parameter int GATE_W = 8,
    parameter int CNT_W  = 16,
    parameter int TS_W   = 32
);
    logic              trig_in;
    logic              enable;
    logic [GATE_W-1:0] gate_len;
    logic [GATE_W-1:0] holdoff_len;
    logic              gate;
    logic              gate_start;
    logic              busy;
    logic [GATE_W-1:0] sample_idx;
    logic [CNT_W-1:0]  trig_cnt;
    logic [CNT_W-1:0]  lost_cnt;
    logic [TS_W-1:0]   trig_ts;
    logic [TS_W-1:0]   ts;
    modport master (
        output trig_in, enable, gate_len, holdoff_len,
        input  gate, gate_start, busy, sample_idx, trig_cnt, lost_cnt, trig_ts, ts
    );
    modport slave (
        input  trig_in, enable, gate_len, holdoff_len,
        output gate, gate_start, busy, sample_idx, trig_cnt, lost_cnt, trig_ts, ts
    );
endinterface

// File: rtl/trig_gate_gen.sv
// trig_gate_gen: trigger to gate+holdoff sequencer with counters and timestamps; define TRIG_GATE_EXTEND_EN to let a gate-time trigger restart the gate
module trig_gate_gen #(
    parameter int GATE_W = 8,
    parameter int CNT_W  = 16,
    parameter int TS_W   = 32
) (
    input logic            clk,
    input logic            rst,
    trig_gate_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GATE, HOLDOFF} state_t;
    state_t            state, state_n;
    logic [GATE_W-1:0] rem, rem_n, glen, glen_n, hlen, hlen_n, idx, idx_n;
    logic [CNT_W-1:0]  trig_cnt, trig_cnt_n, lost_cnt, lost_cnt_n;
    logic [TS_W-1:0]   trig_ts, trig_ts_n, ts;
    logic              gate, gate_n, gate_start, start_n, busy;
    logic              req, accept, retrig;
    always_comb begin
        req        = bus.trig_in & bus.enable;
        accept     = req & (state == IDLE) & (bus.gate_len != '0);
`ifdef TRIG_GATE_EXTEND_EN
        retrig     = req & (state == GATE);
`else
        retrig     = 1'b0;
`endif
        state_n    = state;
        rem_n      = rem;
        glen_n     = glen;
        hlen_n     = hlen;
        idx_n      = '0;
        gate_n     = 1'b0;
        start_n    = 1'b0;
        trig_ts_n  = trig_ts;
        trig_cnt_n = (accept | retrig) & ~&trig_cnt ? trig_cnt + CNT_W'(1) : trig_cnt;
        lost_cnt_n = req & ~accept & ~retrig & ~&lost_cnt ? lost_cnt + CNT_W'(1) : lost_cnt;
        // rem counts the cycles still to come after the current one in GATE or HOLDOFF
        case (state)
            IDLE: if (accept) begin
                state_n   = GATE;
                glen_n    = bus.gate_len;
                hlen_n    = bus.holdoff_len;
                rem_n     = bus.gate_len - GATE_W'(1);
                gate_n    = 1'b1;
                start_n   = 1'b1;
                trig_ts_n = ts;
            end
            GATE: if (retrig || rem != '0) begin
                rem_n  = retrig ? glen - GATE_W'(1) : rem - GATE_W'(1);
                gate_n = 1'b1;
                idx_n  = &idx ? idx : idx + GATE_W'(1);
            end else begin
                state_n = hlen != '0 ? HOLDOFF : IDLE;
                rem_n   = hlen - GATE_W'(1);
            end
            HOLDOFF: begin
                state_n = rem != '0 ? HOLDOFF : IDLE;
                rem_n   = rem - GATE_W'(1);
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rem        <= '0;
            glen       <= '0;
            hlen       <= '0;
            idx        <= '0;
            gate       <= 1'b0;
            gate_start <= 1'b0;
            busy       <= 1'b0;
            trig_cnt   <= '0;
            lost_cnt   <= '0;
            trig_ts    <= '0;
            ts         <= '0;
        end else begin
            state      <= state_n;
            rem        <= rem_n;
            glen       <= glen_n;
            hlen       <= hlen_n;
            idx        <= idx_n;
            gate       <= gate_n;
            gate_start <= start_n;
            busy       <= state_n != IDLE;
            trig_cnt   <= trig_cnt_n;
            lost_cnt   <= lost_cnt_n;
            trig_ts    <= trig_ts_n;
            ts         <= ts + TS_W'(1);
        end
    end
    assign bus.gate       = gate;
    assign bus.gate_start = gate_start;
    assign bus.busy       = busy;
    assign bus.sample_idx = idx;
    assign bus.trig_cnt   = trig_cnt;
    assign bus.lost_cnt   = lost_cnt;
    assign bus.trig_ts    = trig_ts;
    assign bus.ts         = ts;
endmodule

// File: tb/tb_trig_gate_gen.sv
// tb_trig_gate_gen: directed scenarios plus random stimulus against an interval-based reference model
module tb_trig_gate_gen;
`ifdef TRIG_GATE_EXTEND_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   base = 0;
    // model: current gate spans cycles gs..ge, busy spans gs..be
    int   gs = -100, ge = -200, be = -200, glen_l = 0, hlen_l = 0;
    int   m_tc = 0, m_lc = 0;
    logic [31:0] m_tts = '0, m_ts = '0;

    trig_gate_gen_if bus ();
    trig_gate_gen dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [106:0] model_out();
        logic g;
        int   i;
        g = gs <= cyc && cyc <= ge;
        i = g ? (cyc - gs > 255 ? 255 : cyc - gs) : 0;
        return {g, cyc == gs, gs <= cyc && cyc <= be, 8'(i), 16'(m_tc), 16'(m_lc), m_tts, m_ts};
    endfunction

    task automatic tick(input logic t, input logic e, input int gl, input int hl, input logic r);
        bus.trig_in     = t;
        bus.enable      = e;
        bus.gate_len    = 8'(gl);
        bus.holdoff_len = 8'(hl);
        rst             = r;
        if (r) begin
            gs = -100; ge = -200; be = -200;
            m_tc = 0; m_lc = 0; m_tts = '0; m_ts = '0;
        end else begin
            if (t && e) begin
                if (cyc > be && gl != 0) begin
                    gs = cyc + 1; ge = cyc + gl; be = ge + hl;
                    glen_l = gl; hlen_l = hl;
                    m_tc = m_tc < 65535 ? m_tc + 1 : m_tc;
                    m_tts = m_ts;
                end else if (EXT && cyc >= gs && cyc <= ge) begin
                    ge = cyc + glen_l; be = ge + hlen_l;
                    m_tc = m_tc < 65535 ? m_tc + 1 : m_tc;
                end else m_lc = m_lc < 65535 ? m_lc + 1 : m_lc;
            end
            m_ts = m_ts + 32'd1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 0, 0, 1'b1);
        tick(1'b0, 1'b0, 0, 0, 1'b1);
        base = cyc;
    endtask

    task automatic run_to(input int n, input logic e, input int gl, input int hl);
        while (cyc - base < n) tick(1'b0, e, gl, hl, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.gate, bus.gate_start, bus.busy, bus.sample_idx, bus.trig_cnt, bus.lost_cnt, bus.trig_ts, bus.ts} !== 107'd0) begin
            errors++;
            $display("FAIL reset_outputs got gate=%b busy=%b idx=%0d tc=%0d lc=%0d tts=%0d ts=%0d, want all 0",
                     bus.gate, bus.busy, bus.sample_idx, bus.trig_cnt, bus.lost_cnt, bus.trig_ts, bus.ts);
        end
        run_to(3, 1'b1, 4, 2);
        checks++;
        if (bus.ts !== 32'd3 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ts got ts=%0d busy=%b, want ts=3 busy=0", bus.ts, bus.busy);
        end
    endtask

    task automatic test_basic();
        do_reset();
        run_to(10, 1'b1, 4, 2);
        tick(1'b1, 1'b1, 4, 2, 1'b0);
        for (int c = 11; c <= 18; c++) begin
            automatic logic [7:0] ei = c <= 14 ? 8'(c - 11) : 8'd0;
            checks++;
            if (bus.gate !== (c <= 14) || bus.busy !== (c <= 16) || bus.gate_start !== (c == 11) || bus.sample_idx !== ei) begin
                errors++;
                $display("FAIL basic_c%0d got gate=%b busy=%b start=%b idx=%0d, want gate=%b busy=%b start=%b idx=%0d",
                         c, bus.gate, bus.busy, bus.gate_start, bus.sample_idx, c <= 14, c <= 16, c == 11, ei);
            end
            tick(1'b0, 1'b1, 4, 2, 1'b0);
        end
        checks++;
        if (bus.trig_cnt !== 16'd1 || bus.trig_ts !== 32'd10 || bus.lost_cnt !== 16'd0) begin
            errors++;
            $display("FAIL basic_counts got tc=%0d tts=%0d lc=%0d, want 1 10 0", bus.trig_cnt, bus.trig_ts, bus.lost_cnt);
        end
    endtask

    task automatic test_lost();
        automatic int mid = EXT ? 15 : 13;
        do_reset();
        run_to(10, 1'b1, 4, 2);
        tick(1'b1, 1'b1, 4, 2, 1'b0);
        run_to(mid, 1'b1, 4, 2);
        tick(1'b1, 1'b1, 4, 2, 1'b0);
        run_to(16, 1'b1, 4, 2);
        tick(1'b1, 1'b1, 4, 2, 1'b0);
        checks++;
        if (bus.lost_cnt !== 16'd2 || bus.busy !== 1'b0 || bus.trig_cnt !== 16'd1) begin
            errors++;
            $display("FAIL lost_at17 got lc=%0d busy=%b tc=%0d, want 2 0 1", bus.lost_cnt, bus.busy, bus.trig_cnt);
        end
        tick(1'b1, 1'b1, 4, 2, 1'b0);
        checks++;
        if (bus.gate !== 1'b1 || bus.gate_start !== 1'b1 || bus.trig_cnt !== 16'd2 || bus.trig_ts !== 32'd17) begin
            errors++;
            $display("FAIL lost_accept17 got gate=%b start=%b tc=%0d tts=%0d, want 1 1 2 17",
                     bus.gate, bus.gate_start, bus.trig_cnt, bus.trig_ts);
        end
        run_to(21, 1'b1, 4, 2);
        checks++;
        if (bus.gate !== 1'b1 || bus.sample_idx !== 8'd3) begin
            errors++;
            $display("FAIL lost_gate21 got gate=%b idx=%0d, want 1 3", bus.gate, bus.sample_idx);
        end
        tick(1'b0, 1'b1, 4, 2, 1'b0);
        checks++;
        if (bus.gate !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL lost_gate22 got gate=%b busy=%b, want 0 1", bus.gate, bus.busy);
        end
    endtask

    task automatic test_zero_len();
        do_reset();
        run_to(10, 1'b1, 0, 2);
        tick(1'b1, 1'b1, 0, 2, 1'b0);
        for (int c = 11; c <= 13; c++) begin
            checks++;
            if (bus.gate !== 1'b0 || bus.busy !== 1'b0 || bus.lost_cnt !== 16'd1 || bus.trig_cnt !== 16'd0) begin
                errors++;
                $display("FAIL zero_len_c%0d got gate=%b busy=%b lc=%0d tc=%0d, want 0 0 1 0",
                         c, bus.gate, bus.busy, bus.lost_cnt, bus.trig_cnt);
            end
            tick(1'b0, 1'b1, 0, 2, 1'b0);
        end
    endtask

    task automatic test_enable();
        do_reset();
        run_to(10, 1'b0, 4, 2);
        tick(1'b1, 1'b0, 4, 2, 1'b0);
        run_to(20, 1'b0, 4, 2);
        tick(1'b1, 1'b0, 4, 2, 1'b0);
        checks++;
        if (bus.gate !== 1'b0 || bus.busy !== 1'b0 || bus.trig_cnt !== 16'd0 || bus.lost_cnt !== 16'd0) begin
            errors++;
            $display("FAIL enable_off got gate=%b busy=%b tc=%0d lc=%0d, want 0 0 0 0",
                     bus.gate, bus.busy, bus.trig_cnt, bus.lost_cnt);
        end
        do_reset();
        run_to(10, 1'b1, 4, 2);
        tick(1'b1, 1'b1, 4, 2, 1'b0);
        run_to(12, 1'b1, 4, 2);
        tick(1'b1, 1'b0, 4, 2, 1'b0);
        tick(1'b1, 1'b0, 4, 2, 1'b0);
        run_to(14, 1'b0, 4, 2);
        checks++;
        if (bus.gate !== 1'b1 || bus.sample_idx !== 8'd3) begin
            errors++;
            $display("FAIL enable_drop14 got gate=%b idx=%0d, want 1 3", bus.gate, bus.sample_idx);
        end
        tick(1'b0, 1'b0, 4, 2, 1'b0);
        checks++;
        if (bus.gate !== 1'b0 || bus.busy !== 1'b1 || bus.lost_cnt !== 16'd0 || bus.trig_cnt !== 16'd1) begin
            errors++;
            $display("FAIL enable_drop15 got gate=%b busy=%b lc=%0d tc=%0d, want 0 1 0 1",
                     bus.gate, bus.busy, bus.lost_cnt, bus.trig_cnt);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        run_to(10, 1'b1, 4, 2);
        tick(1'b1, 1'b1, 4, 2, 1'b0);
        run_to(12, 1'b1, 4, 2);
        tick(1'b0, 1'b1, 4, 2, 1'b1);
        checks++;
        if (bus.gate !== 1'b0 || bus.busy !== 1'b0 || bus.sample_idx !== 8'd0 || bus.trig_cnt !== 16'd0 || bus.ts !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset13 got gate=%b busy=%b idx=%0d tc=%0d ts=%0d, want all 0",
                     bus.gate, bus.busy, bus.sample_idx, bus.trig_cnt, bus.ts);
        end
        run_to(20, 1'b1, 4, 2);
        tick(1'b1, 1'b1, 4, 2, 1'b0);
        checks++;
        if (bus.gate !== 1'b1 || bus.gate_start !== 1'b1 || bus.trig_cnt !== 16'd1 || bus.trig_ts !== 32'd7) begin
            errors++;
            $display("FAIL mid_reset21 got gate=%b start=%b tc=%0d tts=%0d, want 1 1 1 7",
                     bus.gate, bus.gate_start, bus.trig_cnt, bus.trig_ts);
        end
        run_to(24, 1'b1, 4, 2);
        tick(1'b0, 1'b1, 4, 2, 1'b0);
        checks++;
        if (bus.gate !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset25 got gate=%b busy=%b, want 0 1", bus.gate, bus.busy);
        end
    endtask

    task automatic test_extend();
        automatic int gend = EXT ? 16 : 14;
        do_reset();
        run_to(10, 1'b1, 4, 0);
        for (int c = 10; c <= 18; c++) begin
            if (c >= 11) begin
                automatic logic g = c <= gend;
                automatic logic [7:0] ei = g ? 8'(c - 11) : 8'd0;
                checks++;
                if (bus.gate !== g || bus.sample_idx !== ei || bus.busy !== g) begin
                    errors++;
                    $display("FAIL extend_c%0d got gate=%b idx=%0d busy=%b, want %b %0d %b",
                             c, bus.gate, bus.sample_idx, bus.busy, g, ei, g);
                end
            end
            tick(c == 10 || c == 12, 1'b1, 4, 0, 1'b0);
        end
        checks++;
        if (bus.trig_cnt !== (EXT ? 16'd2 : 16'd1) || bus.lost_cnt !== (EXT ? 16'd0 : 16'd1) || bus.trig_ts !== 32'd10) begin
            errors++;
            $display("FAIL extend_counts got tc=%0d lc=%0d tts=%0d, want %0d %0d 10",
                     bus.trig_cnt, bus.lost_cnt, bus.trig_ts, EXT ? 2 : 1, EXT ? 0 : 1);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            automatic logic [106:0] got = {bus.gate, bus.gate_start, bus.busy, bus.sample_idx,
                                           bus.trig_cnt, bus.lost_cnt, bus.trig_ts, bus.ts};
            automatic logic [106:0] exp = model_out();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_n%0d got %h want %h", n, got, exp);
            end
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 7) != 0, int'($urandom_range(0, 6)),
                 int'($urandom_range(0, 3)), $urandom_range(0, 255) == 0);
        end
    endtask

    task automatic test_saturate();
        automatic logic [106:0] got;
        do_reset();
        repeat (66000) tick(1'b1, 1'b1, 255, 255, 1'b0);
        got = {bus.gate, bus.gate_start, bus.busy, bus.sample_idx, bus.trig_cnt, bus.lost_cnt, bus.trig_ts, bus.ts};
        checks++;
        if ((EXT ? bus.trig_cnt : bus.lost_cnt) !== 16'hffff) begin
            errors++;
            $display("FAIL saturate_cnt got tc=%0d lc=%0d, want saturated 65535", bus.trig_cnt, bus.lost_cnt);
        end
        checks++;
        if (got !== model_out()) begin
            errors++;
            $display("FAIL saturate_all got %h want %h", got, model_out());
        end
    endtask

    initial begin
        bus.trig_in     = 1'b0;
        bus.enable      = 1'b0;
        bus.gate_len    = '0;
        bus.holdoff_len = '0;
        test_reset();
        test_basic();
        test_lost();
        test_zero_len();
        test_enable();
        test_mid_reset();
        test_extend();
        test_random();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
